// File: rtl/dac_sample_feeder_if.sv
// Source-side pair handshake for dac_sample_feeder: the source drives the
// two channel samples with a valid flag, and the feeder answers with ready.
interface dac_sample_feeder_if #(
    parameter int W = 10
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;

    modport master (
        output s_valid,
        output s_a,
        output s_b,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_a,
        input  s_b,
        output s_ready
    );
endinterface

// File: rtl/dac_sample_feeder.sv
// Pair FIFO feeding an interleaved A/B word stream to the DAC formatter.
// It substitutes the idle code, and counts the event, whenever an A slot finds the FIFO empty.
module dac_sample_feeder #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [9:0]  IDLE_CODE = 10'h200
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    enable,
    dac_sample_feeder_if.slave      src,
    output logic [15:0]             dout,
    output logic                    phase,
    output logic                    underflow,
    output logic [15:0]             underflow_count,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // HELD_A: dout carries an A word, so the next edge is the B slot.
    // HELD_B: dout carries a B or idle word, so the next edge is an A boundary.
    typedef enum logic {
        HELD_A = 1'b0,
        HELD_B = 1'b1
    } slot_t;

    logic [9:0]    mem_a [DEPTH];
    logic [9:0]    mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [9:0]    hold;
    slot_t         slot;

    logic          push;
    logic          pop;
    logic          fifo_empty;

    function automatic logic [15:0] pad_word(input logic [9:0] w);
        return {6'd0, w};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Ready depends only on the registered level, never on the source inputs.
    assign src.s_ready = (level < LW'(DEPTH));
    assign fifo_empty  = (level == '0);
    assign push        = src.s_valid && src.s_ready;
    assign pop         = (slot == HELD_B) && enable && !fifo_empty;
    assign phase       = slot;

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= src.s_a;
            mem_b[wr_ptr] <= src.s_b;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Slot sequencer: an A boundary either pops a pair, substitutes idle, or
    // idles in place while disabled; a started pair always finishes its B word.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            slot            <= HELD_B;
            dout            <= pad_word(IDLE_CODE);
            hold            <= IDLE_CODE;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else begin
            underflow <= 1'b0;
            case (slot)
                HELD_B: begin
                    if (enable) begin
                        slot <= HELD_A;
                        if (fifo_empty) begin
                            dout            <= pad_word(IDLE_CODE);
                            hold            <= IDLE_CODE;
                            underflow       <= 1'b1;
                            underflow_count <= sat_inc(underflow_count);
                        end else begin
                            dout <= pad_word(mem_a[rd_ptr]);
                            hold <= mem_b[rd_ptr];
                        end
                    end else begin
                        dout <= pad_word(IDLE_CODE);
                    end
                end
                HELD_A: begin
                    dout <= pad_word(hold);
                    slot <= HELD_B;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder with a queue-based reference model
// that is compared against every output on every falling clock edge.
module tb_dac_sample_feeder;
    localparam int          DEPTH = 8;
    localparam logic [9:0]  IDLE  = 10'h200;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] dout;
    logic        phase;
    logic        underflow;
    logic [15:0] underflow_count;
    logic [3:0]  level;

    dac_sample_feeder_if #(.W(10)) src_if ();

    dac_sample_feeder #(.DEPTH(DEPTH), .IDLE_CODE(IDLE)) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .enable          (enable),
        .src             (src_if.slave),
        .dout            (dout),
        .phase           (phase),
        .underflow       (underflow),
        .underflow_count (underflow_count),
        .level           (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model; the queues are the scoreboard of accepted pairs.
    logic [9:0]  qa[$];
    logic [9:0]  qb[$];
    logic        m_phase;
    logic [9:0]  m_hold;
    logic [15:0] m_dout;
    logic [15:0] m_cnt;
    logic        m_uf;
    bit          m_acc;

    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            qa.delete();
            qb.delete();
            m_phase = 1'b1;
            m_hold  = IDLE;
            m_dout  = {6'd0, IDLE};
            m_uf    = 1'b0;
            m_cnt   = 16'd0;
        end else begin
            m_acc = src_if.s_valid && (qa.size() < DEPTH);
            m_uf  = 1'b0;
            if (m_phase) begin
                if (enable) begin
                    if (qa.size() > 0) begin
                        m_dout = {6'd0, qa.pop_front()};
                        m_hold = qb.pop_front();
                    end else begin
                        m_dout = {6'd0, IDLE};
                        m_hold = IDLE;
                        m_uf   = 1'b1;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                    m_phase = 1'b0;
                end else begin
                    m_dout = {6'd0, IDLE};
                end
            end else begin
                m_dout  = {6'd0, m_hold};
                m_phase = 1'b1;
            end
            if (m_acc) begin
                qa.push_back(src_if.s_a);
                qb.push_back(src_if.s_b);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_in === 1'b1) begin
            chk("sb_dout", dout, m_dout);
            chk("sb_phase", phase, m_phase);
            chk("sb_underflow", underflow, m_uf);
            chk("sb_count", underflow_count, m_cnt);
            chk("sb_level", level, qa.size());
            chk("sb_ready", src_if.s_ready, (qa.size() < DEPTH));
        end
    end

    int uf_seen;
    int n;
    bit pushed;

    initial begin
        src_if.s_valid = 1'b0;
        src_if.s_a     = '0;
        src_if.s_b     = '0;
        repeat (2) tick();
        chk("rst_dout", dout, 16'h0200);
        chk("rst_phase", phase, 1'b1);
        chk("rst_level", level, 4'd0);
        chk("rst_count", underflow_count, 16'd0);
        chk("rst_uf", underflow, 1'b0);
        rst_in = 1'b1;
        tick();
        chk("ready_after_rst", src_if.s_ready, 1'b1);

        // Basic stream with two back-to-back pairs
        src_if.s_valid = 1'b1; src_if.s_a = 10'h001; src_if.s_b = 10'h3FF;
        tick();
        chk("basic_level1", level, 4'd1);
        src_if.s_a = 10'h155; src_if.s_b = 10'h2AA; enable = 1'b1;
        tick();
        chk("basic_a0", dout, 16'h0001); chk("basic_ph0", phase, 1'b0);
        chk("basic_simul_level", level, 4'd1);
        src_if.s_valid = 1'b0;
        tick();
        chk("basic_b0", dout, 16'h03FF); chk("basic_ph1", phase, 1'b1);
        tick();
        chk("basic_a1", dout, 16'h0155); chk("basic_ph2", phase, 1'b0);
        tick();
        chk("basic_b1", dout, 16'h02AA); chk("basic_ph3", phase, 1'b1);
        tick();
        chk("basic_idle", dout, 16'h0200); chk("basic_uf", underflow, 1'b1);
        chk("basic_cnt1", underflow_count, 16'd1);
        tick();
        chk("basic_uf_low", underflow, 1'b0); chk("basic_ph5", phase, 1'b1);
        tick();
        chk("basic_uf2", underflow, 1'b1); chk("basic_cnt2", underflow_count, 16'd2);

        // Asynchronous reset with three pairs buffered
        enable = 1'b0;
        tick();
        src_if.s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            src_if.s_a = 10'(k + 'h40); src_if.s_b = 10'(k + 'h50);
            tick();
        end
        src_if.s_valid = 1'b0;
        chk("pre_rst_level", level, 4'd3);
        #1 rst_in = 1'b0;
        #1;
        chk("async_rst_dout", dout, 16'h0200);
        chk("async_rst_phase", phase, 1'b1);
        chk("async_rst_level", level, 4'd0);
        chk("async_rst_count", underflow_count, 16'd0);
        tick();
        rst_in = 1'b1;
        tick();
        chk("ready_after_rst2", src_if.s_ready, 1'b1);

        // Underflow counting on an empty FIFO
        enable = 1'b1;
        uf_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (underflow === 1'b1) uf_seen++;
            chk("uf_dout_idle", dout, 16'h0200);
        end
        chk("uf_pulses", uf_seen, 5);
        chk("uf_count5", underflow_count, 16'd5);

        // Saturation from a count placed just below the ceiling
        force dut.underflow_count = 16'hFFFD;
        m_cnt = 16'hFFFD;
        #1 release dut.underflow_count;
        tick();
        chk("sat_fffe", underflow_count, 16'hFFFE);
        tick();
        tick();
        chk("sat_ffff", underflow_count, 16'hFFFF);
        tick();
        tick();
        chk("sat_hold", underflow_count, 16'hFFFF);
        chk("sat_uf_still", underflow, 1'b1);

        // Fill and backpressure
        enable = 1'b0;
        tick();
        tick();
        src_if.s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            src_if.s_a = 10'(k + 'h10); src_if.s_b = 10'(k + 'h30);
            tick();
        end
        src_if.s_a = 10'h018; src_if.s_b = 10'h038;
        tick();
        tick();
        chk("fill_level", level, 4'd8);
        chk("fill_ready_low", src_if.s_ready, 1'b0);
        enable = 1'b1;
        tick();
        chk("fill_first_a", dout, 16'h0010);
        chk("fill_ready_back", src_if.s_ready, 1'b1);
        tick();
        chk("fill_ninth_in", level, 4'd8);
        src_if.s_valid = 1'b0;
        repeat (15) tick();
        chk("fill_ninth_a", dout, 16'h0018);
        tick();
        chk("fill_ninth_b", dout, 16'h0038);

        // Enable dropped while the A word is on the bus
        enable = 1'b0;
        src_if.s_valid = 1'b1; src_if.s_a = 10'h0AB; src_if.s_b = 10'h0CD;
        tick();
        src_if.s_a = 10'h011; src_if.s_b = 10'h022;
        tick();
        src_if.s_valid = 1'b0;
        chk("mid_level2", level, 4'd2);
        enable = 1'b1;
        tick();
        chk("mid_a", dout, 16'h00AB); chk("mid_ph_a", phase, 1'b0);
        enable = 1'b0;
        tick();
        chk("mid_b", dout, 16'h00CD); chk("mid_ph_b", phase, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_idle", dout, 16'h0200);
            chk("mid_idle_ph", phase, 1'b1);
            chk("mid_no_pop", level, 4'd1);
        end
        enable = 1'b1;
        tick();
        chk("mid_resume_a", dout, 16'h0011);
        tick();
        chk("mid_resume_b", dout, 16'h0022);
        enable = 1'b0;
        tick();

        // Simultaneous push/pop at level 4 across several pointer wraps
        src_if.s_valid = 1'b1;
        for (n = 0; n < 4; n++) begin
            src_if.s_a = 10'(n); src_if.s_b = 10'(10'h3FF - n);
            tick();
        end
        src_if.s_valid = 1'b0;
        chk("simul_level4", level, 4'd4);
        enable = 1'b1;
        while (n < 3 * DEPTH + 4) begin
            pushed = m_phase;
            src_if.s_valid = pushed;
            src_if.s_a = 10'(n); src_if.s_b = 10'(10'h3FF - n);
            tick();
            if (pushed) begin
                chk("simul_level_hold", level, 4'd4);
                n++;
            end
        end
        src_if.s_valid = 1'b0;
        repeat (10) tick();
        chk("simul_drained", level, 4'd0);
        enable = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
